oc8051_tcn: RTL and testbench

Parametrised multi-channel timer/counter for the oc8051 SFR space. It provides CHANNELS independent up-counters of WIDTH bits sharing one prescaler, and sits on the core's SFR bus alongside the legacy timer block. Each channel supports free-run, auto-reload, one-shot and input-capture modes, with gated or external-event counting. Per-channel flags are ORed onto a single interrupt request.

---
 rtl/oc8051_tcn_pkg.sv | 51 +++++
 rtl/oc8051_tcn_chan.sv | 150 +++++++++++++++
 rtl/oc8051_tcn.sv | 140 ++++++++++++++
 tb/tb_oc8051_tcn.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_tcn_pkg.sv
// oc8051_tcn_pkg
// Shared definitions for the multi-channel timer/counter:
//   - register offsets inside the prescaler block and each channel block
//   - MODE encodings
//   - CTRL / STATUS bit positions
//   - reset values
//   - set_byte(): replaces one byte of a 16-bit register image
package oc8051_tcn_pkg;

  // Offsets inside a channel's 8-byte block
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CNT_L  = 3'd2;
  localparam logic [2:0] OFF_CNT_H  = 3'd3;
  localparam logic [2:0] OFF_RLD_L  = 3'd4;
  localparam logic [2:0] OFF_RLD_H  = 3'd5;
  localparam logic [2:0] OFF_CAP_L  = 3'd6;
  localparam logic [2:0] OFF_CAP_H  = 3'd7;

  // PRESC is the only register in the block at ADDR_BASE
  localparam logic [2:0] OFF_PRESC  = 3'd0;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_CAPTURE = 2'b11
  } tcn_mode_e;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_GATE    = 1;
  localparam int CTRL_EXT     = 2;
  localparam int CTRL_MODE_LO = 3;
  localparam int CTRL_MODE_HI = 4;
  localparam int CTRL_IE      = 5;

  localparam int STATUS_OVF  = 0;
  localparam int STATUS_CAPF = 1;

  localparam logic [7:0] PRESC_RST = 8'h00;

  // Byte-lane write into a 16-bit register image
  function automatic logic [15:0] set_byte(input logic [15:0] cur,
                                           input logic        hi,
                                           input logic [7:0]  b);
    set_byte = cur;
    if (hi) set_byte[15:8] = b;
    else    set_byte[7:0]  = b;
  endfunction

endpackage

// File: rtl/oc8051_tcn_chan.sv
// oc8051_tcn_chan
// One timer/counter channel: input synchronisers, falling-edge detect,
// WIDTH-bit up-counter with free-run / reload / one-shot / capture modes,
// OVF/CAPF flags with write-1-to-clear, and the channel's SFR registers.
// Ports:
//   clk, rst            clock, async active-high reset
//   tick                shared prescaler pulse
//   wr_en, wr_off       byte write to this channel's block, offset 0..7
//   data_in             write data
//   gate_n, ev_in,      per-channel pins (ev_in/cap_in asynchronous)
//   cap_in
//   ctrl_rd, status_rd  read images of CTRL/STATUS
//   cnt_rd, rld_rd,     16-bit zero-extended register images
//   cap_rd
//   flag, irq_req       OVF|CAPF, and flag qualified by IE
module oc8051_tcn_chan
  import oc8051_tcn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [7:0]  data_in,
  input  logic        gate_n,
  input  logic        ev_in,
  input  logic        cap_in,
  output logic [7:0]  ctrl_rd,
  output logic [7:0]  status_rd,
  output logic [15:0] cnt_rd,
  output logic [15:0] rld_rd,
  output logic [15:0] cap_rd,
  output logic        flag,
  output logic        irq_req
);

  logic             run, gate, ext, ie;
  tcn_mode_e        mode;
  logic             ovf, capf;
  logic [WIDTH-1:0] cnt, rld, cap, cnt_next;
  logic [2:0]       ev_sync, cap_sync;
  logic             ev_fall, cap_fall;
  logic             inc, tc, cap_evt;
  logic             wr_ctrl, wr_status, wr_cnt, wr_rld;
  logic [15:0]      cnt_wr_val, rld_wr_val;

  // Two flops resynchronise the pin, the third holds the previous
  // synchronised level so a falling edge is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_sync  <= 3'b000;
      cap_sync <= 3'b000;
    end else begin
      ev_sync  <= {ev_sync[1:0], ev_in};
      cap_sync <= {cap_sync[1:0], cap_in};
    end
  end

  assign ev_fall  = ev_sync[2] & ~ev_sync[1];
  assign cap_fall = cap_sync[2] & ~cap_sync[1];

  assign inc     = run & (~gate | ~gate_n) & (ext ? ev_fall : tick);
  assign tc      = inc & (cnt == {WIDTH{1'b1}});
  assign cap_evt = (mode == MODE_CAPTURE) & cap_fall;

  assign wr_ctrl   = wr_en & (wr_off == OFF_CTRL);
  assign wr_status = wr_en & (wr_off == OFF_STATUS);
  assign wr_cnt    = wr_en & ((wr_off == OFF_CNT_L) | (wr_off == OFF_CNT_H));
  assign wr_rld    = wr_en & ((wr_off == OFF_RLD_L) | (wr_off == OFF_RLD_H));

  // Zero-extended images; bits above WIDTH-1 read as 0 and writes to
  // them are dropped when the merged value is truncated back to WIDTH.
  always_comb begin
    cnt_rd = 16'h0000;
    rld_rd = 16'h0000;
    cap_rd = 16'h0000;
    cnt_rd[WIDTH-1:0] = cnt;
    rld_rd[WIDTH-1:0] = rld;
    cap_rd[WIDTH-1:0] = cap;
  end

  assign cnt_wr_val = set_byte(cnt_rd, wr_off == OFF_CNT_H, data_in);
  assign rld_wr_val = set_byte(rld_rd, wr_off == OFF_RLD_H, data_in);

  // A CPU write replaces one byte of the pre-increment count, so the
  // other byte does not move in that cycle.
  always_comb begin
    cnt_next = cnt;
    if (wr_cnt) begin
      cnt_next = cnt_wr_val[WIDTH-1:0];
    end else if (tc) begin
      if ((mode == MODE_RELOAD) || (mode == MODE_ONESHOT)) cnt_next = rld;
      else                                                 cnt_next = '0;
    end else if (inc) begin
      cnt_next = cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rld <= '0;
      cap <= '0;
    end else begin
      cnt <= cnt_next;
      if (wr_rld)  rld <= rld_wr_val[WIDTH-1:0];
      if (cap_evt) cap <= cnt;
    end
  end

  // A one-shot drops RUN at terminal count unless the CPU rewrites CTRL
  // in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      gate <= 1'b0;
      ext  <= 1'b0;
      ie   <= 1'b0;
      mode <= MODE_FREE;
    end else if (wr_ctrl) begin
      run  <= data_in[CTRL_RUN];
      gate <= data_in[CTRL_GATE];
      ext  <= data_in[CTRL_EXT];
      ie   <= data_in[CTRL_IE];
      mode <= tcn_mode_e'(data_in[CTRL_MODE_HI:CTRL_MODE_LO]);
    end else if (tc && (mode == MODE_ONESHOT)) begin
      run  <= 1'b0;
    end
  end

  // Setting wins over a same-cycle write-1-to-clear. Terminal count
  // still raises OVF even when a CNT write overrides the counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      capf <= 1'b0;
    end else begin
      ovf  <= tc      | (ovf  & ~(wr_status & data_in[STATUS_OVF]));
      capf <= cap_evt | (capf & ~(wr_status & data_in[STATUS_CAPF]));
    end
  end

  assign ctrl_rd   = {2'b00, ie, mode, ext, gate, run};
  assign status_rd = {6'b000000, capf, ovf};
  assign flag      = ovf | capf;
  assign irq_req   = flag & ie;

endmodule

// File: rtl/oc8051_tcn.sv
// oc8051_tcn
// Multi-channel timer/counter on the oc8051 SFR bus. Holds the shared
// 8-bit prescaler, SFR address decode, registered read mux with write
// bypass, and the interrupt OR; per-channel logic lives in oc8051_tcn_chan.
// Ports:
//   clk, rst          clock, async active-high reset
//   wr, wr_bit        byte write when wr & !wr_bit
//   wr_addr, data_in  write address / data
//   rd_addr, data_out read address / registered read data
//   gate_n, ev_in,    per-channel pins
//   cap_in
//   flag              per-channel OVF|CAPF
//   irq               OR of (flag & IE) over channels
module oc8051_tcn
  import oc8051_tcn_pkg::*;
#(
  parameter int         CHANNELS  = 2,
  parameter int         WIDTH     = 16,
  parameter logic [7:0] ADDR_BASE = 8'hC0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic                wr_bit,
  input  logic [7:0]          wr_addr,
  input  logic [7:0]          rd_addr,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic [CHANNELS-1:0] gate_n,
  input  logic [CHANNELS-1:0] ev_in,
  input  logic [CHANNELS-1:0] cap_in,
  output logic [CHANNELS-1:0] flag,
  output logic                irq
);

  logic                byte_wr;
  logic [7:0]          presc, presc_cnt;
  logic                tick;
  logic                presc_wr_hit, presc_rd_hit;
  logic [CHANNELS-1:0] wr_hit, rd_hit, irq_vec;
  logic [7:0]          ch_ctrl   [CHANNELS];
  logic [7:0]          ch_status [CHANNELS];
  logic [15:0]         ch_cnt    [CHANNELS];
  logic [15:0]         ch_rld    [CHANNELS];
  logic [15:0]         ch_cap    [CHANNELS];
  logic [7:0]          rd_mux;
  logic                rd_mapped;

  assign byte_wr = wr & ~wr_bit;

  assign presc_wr_hit = (wr_addr[7:3] == ADDR_BASE[7:3]) && (wr_addr[2:0] == OFF_PRESC);
  assign presc_rd_hit = (rd_addr[7:3] == ADDR_BASE[7:3]) && (rd_addr[2:0] == OFF_PRESC);

  // Comparing with >= lets the counter recover at once when PRESC is
  // lowered below the current count.
  assign tick = (presc_cnt >= presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= PRESC_RST;
      presc_cnt <= 8'h00;
    end else begin
      presc_cnt <= tick ? 8'h00 : presc_cnt + 8'h01;
      if (byte_wr && presc_wr_hit) presc <= data_in;
    end
  end

  // Channel blocks are decoded with a 9-bit compare so an address range
  // running past 8'hFF never aliases onto low addresses.
  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_chan
      localparam logic [8:0] CH_BASE = {1'b0, ADDR_BASE} + 9'(8 * (g + 1));

      assign wr_hit[g] = ({1'b0, wr_addr[7:3], 3'b000} == CH_BASE);
      assign rd_hit[g] = ({1'b0, rd_addr[7:3], 3'b000} == CH_BASE);

      oc8051_tcn_chan #(
        .WIDTH(WIDTH)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .wr_en     (byte_wr & wr_hit[g]),
        .wr_off    (wr_addr[2:0]),
        .data_in   (data_in),
        .gate_n    (gate_n[g]),
        .ev_in     (ev_in[g]),
        .cap_in    (cap_in[g]),
        .ctrl_rd   (ch_ctrl[g]),
        .status_rd (ch_status[g]),
        .cnt_rd    (ch_cnt[g]),
        .rld_rd    (ch_rld[g]),
        .cap_rd    (ch_cap[g]),
        .flag      (flag[g]),
        .irq_req   (irq_vec[g])
      );
    end
  endgenerate

  assign irq = |irq_vec;

  always_comb begin
    rd_mux    = 8'h00;
    rd_mapped = 1'b0;
    if (presc_rd_hit) begin
      rd_mux    = presc;
      rd_mapped = 1'b1;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_hit[i]) begin
        rd_mapped = 1'b1;
        case (rd_addr[2:0])
          OFF_CTRL:   rd_mux = ch_ctrl[i];
          OFF_STATUS: rd_mux = ch_status[i];
          OFF_CNT_L:  rd_mux = ch_cnt[i][7:0];
          OFF_CNT_H:  rd_mux = ch_cnt[i][15:8];
          OFF_RLD_L:  rd_mux = ch_rld[i][7:0];
          OFF_RLD_H:  rd_mux = ch_rld[i][15:8];
          OFF_CAP_L:  rd_mux = ch_cap[i][7:0];
          OFF_CAP_H:  rd_mux = ch_cap[i][15:8];
          default:    rd_mux = 8'h00;
        endcase
      end
    end
  end

  // Reading the address being written returns the new byte straight away
  // rather than the stale register contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (byte_wr && (wr_addr == rd_addr) && rd_mapped) begin
      data_out <= data_in;
    end else begin
      data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_oc8051_tcn.sv
// tb_oc8051_tcn
// Directed bench for oc8051_tcn with default parameters (2 channels,
// 16-bit, base 8'hC0). Channel 0 block at C8..CF, channel 1 at D0..D7.
// Inputs change just after the falling edge; outputs are sampled there.
module tb_oc8051_tcn;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, wr_bit;
  logic [7:0] wr_addr, rd_addr, data_in;
  logic [7:0] data_out;
  logic [1:0] gate_n, ev_in, cap_in;
  logic [1:0] flag;
  logic       irq;

  int         checks = 0;
  int         errors = 0;
  int         n;
  logic [7:0] rv;

  oc8051_tcn #(
    .CHANNELS  (2),
    .WIDTH     (16),
    .ADDR_BASE (8'hC0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .wr_bit   (wr_bit),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .data_in  (data_in),
    .data_out (data_out),
    .gate_n   (gate_n),
    .ev_in    (ev_in),
    .cap_in   (cap_in),
    .flag     (flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // One-cycle SFR byte write; entered and left on a falling edge
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] d);
    wr_addr = addr;
    data_in = d;
    wr      = 1'b1;
    @(negedge clk);
    wr      = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] addr, output logic [7:0] v);
    rd_addr = addr;
    @(negedge clk);
    v = data_out;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkOutput(tag, {8'h00, obs}, {8'h00, exp});
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {15'h0000, obs}, {15'h0000, exp});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; wr_bit = 1'b0;
    wr_addr = 8'h00; rd_addr = 8'h00; data_in = 8'h00;
    gate_n = 2'b11; ev_in = 2'b00; cap_in = 2'b00;
    repeat (3) @(negedge clk);
    checkByte("reset_data_out", data_out, 8'h00);
    checkOutput("reset_flag", {14'h0, flag}, 16'h0000);
    checkBit("reset_irq", irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // FREE, PRESC=0, start at FFFE with IE
    applyStimulus(8'hCA, 8'hFE);
    applyStimulus(8'hCB, 8'hFF);
    rd_addr = 8'hCA;
    applyStimulus(8'hC8, 8'h21);
    @(negedge clk);
    checkBit("free_flag_before_wrap", flag[0], 1'b0);
    @(negedge clk);
    checkByte("free_cnt_ff_seen", data_out, 8'hFF);
    checkBit("free_flag_at_wrap", flag[0], 1'b1);
    checkBit("free_irq_at_wrap", irq, 1'b1);
    applyStimulus(8'hC8, 8'h20);
    checkByte("free_cnt_wrapped", data_out, 8'h00);
    readReg(8'hCA, rv); checkByte("free_cnt_l_stop", rv, 8'h01);
    readReg(8'hCB, rv); checkByte("free_cnt_h_stop", rv, 8'h00);
    readReg(8'hC9, rv); checkByte("free_status", rv, 8'h01);
    applyStimulus(8'hC9, 8'h01);
    checkBit("free_flag_cleared", flag[0], 1'b0);
    checkBit("free_irq_cleared", irq, 1'b0);

    // RELOAD, RLD=FFFC, PRESC=3
    applyStimulus(8'hC0, 8'h03);
    applyStimulus(8'hCC, 8'hFC);
    applyStimulus(8'hCD, 8'hFF);
    applyStimulus(8'hCA, 8'hFC);
    applyStimulus(8'hCB, 8'hFF);
    rd_addr = 8'hCA;
    applyStimulus(8'hC8, 8'h09);
    n = 0;
    while (flag[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkBit("rld_first_ovf", flag[0], 1'b1);
    applyStimulus(8'hC9, 8'h01);
    checkByte("rld_cnt_reloaded", data_out, 8'hFC);
    checkBit("rld_flag_cleared", flag[0], 1'b0);
    repeat (4) @(negedge clk);
    checkByte("rld_step_after_4", data_out, 8'hFD);
    n = 0;
    while (flag[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rld_ovf_period", 16'(n), 16'd11);
    checkByte("rld_cnt_before_reload", data_out, 8'hFF);
    applyStimulus(8'hC8, 8'h00);
    applyStimulus(8'hC9, 8'h01);
    applyStimulus(8'hC0, 8'h00);

    // ONESHOT from FFFF with RLD=1234
    applyStimulus(8'hCA, 8'hFF);
    applyStimulus(8'hCB, 8'hFF);
    applyStimulus(8'hCC, 8'h34);
    applyStimulus(8'hCD, 8'h12);
    applyStimulus(8'hC8, 8'h11);
    @(negedge clk);
    readReg(8'hC8, rv); checkByte("os_run_cleared", rv, 8'h10);
    repeat (3) @(negedge clk);
    readReg(8'hCA, rv); checkByte("os_cnt_l", rv, 8'h34);
    readReg(8'hCB, rv); checkByte("os_cnt_h", rv, 8'h12);
    readReg(8'hC9, rv); checkByte("os_status", rv, 8'h01);
    applyStimulus(8'hC9, 8'h01);

    // Channel 1: EXT + GATE, ev_in pulses counted only when gate_n low
    applyStimulus(8'hD0, 8'h07);
    rd_addr = 8'hD2;
    gate_n[1] = 1'b0;
    ev_in[1]  = 1'b1;
    repeat (2) @(negedge clk);
    ev_in[1]  = 1'b0;
    repeat (3) @(negedge clk);
    checkByte("ext_not_yet", data_out, 8'h00);
    @(negedge clk);
    checkByte("ext_first_count", data_out, 8'h01);
    for (int p = 0; p < 4; p++) begin
      gate_n[1] = (p % 2 == 0);
      ev_in[1]  = 1'b1;
      repeat (2) @(negedge clk);
      ev_in[1]  = 1'b0;
      repeat (4) @(negedge clk);
    end
    checkByte("ext_gated_total", data_out, 8'h03);
    applyStimulus(8'hD0, 8'h00);
    gate_n[1] = 1'b1;

    // CAPTURE on channel 0
    applyStimulus(8'hCA, 8'h30);
    applyStimulus(8'hCB, 8'h12);
    cap_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8'hC8, 8'h19);
    @(negedge clk);
    cap_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    checkBit("cap_flag_before", flag[0], 1'b0);
    @(negedge clk);
    checkBit("cap_flag_set", flag[0], 1'b1);
    cap_in[0] = 1'b1;
    readReg(8'hCE, rv); checkByte("cap_l_first", rv, 8'h33);
    readReg(8'hCF, rv); checkByte("cap_h_first", rv, 8'h12);
    cap_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(8'hC9, 8'h02);
    checkBit("cap_set_beats_clear", flag[0], 1'b1);
    applyStimulus(8'hC8, 8'h18);
    readReg(8'hCE, rv); checkByte("cap_l_overwritten", rv, 8'h38);
    readReg(8'hCF, rv); checkByte("cap_h_overwritten", rv, 8'h12);
    readReg(8'hC9, rv); checkByte("cap_status", rv, 8'h02);
    applyStimulus(8'hC9, 8'h02);
    checkBit("cap_flag_cleared", flag[0], 1'b0);

    // CPU CNT write in the same cycle as terminal count
    applyStimulus(8'hCA, 8'hFF);
    applyStimulus(8'hCB, 8'hFF);
    rd_addr = 8'hCA;
    applyStimulus(8'hC8, 8'h01);
    applyStimulus(8'hCA, 8'h55);
    @(negedge clk);
    checkByte("coll_write_wins", data_out, 8'h55);
    applyStimulus(8'hC8, 8'h00);
    applyStimulus(8'hC9, 8'h03);

    // Write bypass, bit-write qualifier, unmapped read, CTRL masking
    rd_addr = 8'hCC;
    applyStimulus(8'hCC, 8'hA5);
    checkByte("bypass", data_out, 8'hA5);
    wr_bit = 1'b1;
    applyStimulus(8'hCC, 8'h77);
    wr_bit = 1'b0;
    readReg(8'hCC, rv); checkByte("wr_bit_ignored", rv, 8'hA5);
    readReg(8'hC3, rv); checkByte("unmapped", rv, 8'h00);
    applyStimulus(8'hD0, 8'hE0);
    readReg(8'hD0, rv); checkByte("ctrl_mask", rv, 8'h20);

    // Reset mid-count with a pending interrupt
    applyStimulus(8'hCA, 8'hFE);
    applyStimulus(8'hCB, 8'hFF);
    rd_addr = 8'hCA;
    applyStimulus(8'hC8, 8'h21);
    repeat (2) @(negedge clk);
    checkBit("pre_rst_irq", irq, 1'b1);
    rst = 1'b1;
    #1;
    checkByte("rst_data_out", data_out, 8'h00);
    checkOutput("rst_flag", {14'h0, flag}, 16'h0000);
    checkBit("rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    readReg(8'hC8, rv); checkByte("rst_ctrl", rv, 8'h00);
    readReg(8'hCA, rv); checkByte("rst_cnt_l", rv, 8'h00);
    readReg(8'hC0, rv); checkByte("rst_presc", rv, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
